// File: rtl/layer_serializer_if.sv
// Ready/valid bus between a fully-parallel layer, the serializer and the next serial consumer.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface layer_serializer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           in_valid;
    logic [NN*dataWidth-1:0] in_data;
    logic                    out_ready;
    logic                    out_valid;
    logic [dataWidth-1:0]    out_data;
    logic                    out_last;
    logic                    busy;
    logic                    overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, busy, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, busy, overflow
    );
endinterface

// File: rtl/layer_serializer.sv
// Collects NN skewed neuron results into a fill buffer, then replays them lane 0 first
// from a separate drain buffer as a ready/valid stream (double-buffered).
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic               clk,
    input  logic               rstn,
    layer_serializer_if.slave  bus
);
    localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

    typedef enum logic {
        DRAIN_EMPTY,
        DRAIN_FULL
    } drainState_t;

    logic [NN-1:0]        r_mask;
    logic [dataWidth-1:0] r_fill  [NN];
    logic [dataWidth-1:0] r_drain [NN];
    drainState_t          r_state;
    logic [IDXW-1:0]      r_index;
    logic [dataWidth-1:0] r_outData;
    logic                 r_outLast;
    logic                 r_busy;
    logic                 r_overflow;

    logic [NN-1:0]        w_accept;
    logic [NN-1:0]        w_collide;
    logic                 w_fillComplete;
    logic                 w_handshake;
    logic                 w_lastBeat;
    logic                 w_drainFree;
    logic                 w_transfer;
    logic [NN-1:0]        w_maskNext;
    logic                 w_occNext;
    logic [IDXW-1:0]      w_nextIndex;
    logic [dataWidth-1:0] w_merged [NN];

    assign w_accept       = bus.in_valid & ~r_mask;
    assign w_collide      = bus.in_valid & r_mask;
    assign w_fillComplete = &(r_mask | bus.in_valid);
    assign w_handshake    = (r_state == DRAIN_FULL) && bus.out_ready;
    assign w_lastBeat     = w_handshake && (r_index == LAST_IDX);
    assign w_drainFree    = (r_state == DRAIN_EMPTY) || w_lastBeat;
    assign w_transfer     = w_fillComplete && w_drainFree;
    assign w_nextIndex    = r_index + IDXW'(1);

    // Lanes already captured that strobe again on the transfer edge seed the next frame.
    assign w_maskNext = w_transfer ? w_collide : (r_mask | bus.in_valid);
    assign w_occNext  = w_transfer || ((r_state == DRAIN_FULL) && !w_lastBeat);

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            w_merged[i] = w_accept[i] ? bus.in_data[i*dataWidth +: dataWidth] : r_fill[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mask     <= '0;
            r_state    <= DRAIN_EMPTY;
            r_index    <= '0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (w_accept[i] || (w_transfer && w_collide[i])) begin
                    r_fill[i] <= bus.in_data[i*dataWidth +: dataWidth];
                end
            end
            r_mask <= w_maskNext;
            r_busy <= (w_maskNext != '0) || w_occNext;
            if (!w_transfer && (w_collide != '0)) begin
                r_overflow <= 1'b1;
            end

            // Output word and last flag are precomputed so they leave straight from flops.
            if (w_transfer) begin
                for (int i = 0; i < NN; i++) begin
                    r_drain[i] <= w_merged[i];
                end
                r_state   <= DRAIN_FULL;
                r_index   <= '0;
                r_outData <= w_merged[0];
                r_outLast <= 1'b0;
            end else if (w_lastBeat) begin
                r_state   <= DRAIN_EMPTY;
                r_index   <= '0;
                r_outData <= '0;
                r_outLast <= 1'b0;
            end else if (w_handshake) begin
                r_index   <= w_nextIndex;
                r_outData <= r_drain[w_nextIndex];
                r_outLast <= (w_nextIndex == LAST_IDX);
            end
        end
    end

    assign bus.out_valid = (r_state == DRAIN_FULL);
    assign bus.out_data  = r_outData;
    assign bus.out_last  = r_outLast;
    assign bus.busy      = r_busy;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer with NN=4: frames push expected words into a queue,
// a negedge monitor pops and compares every accepted word and checks stall stability.
module tb_layer_serializer;
    localparam int NN = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } expWord_t;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   hsCount = 0;
    int   lastCount = 0;
    expWord_t expQ[$];

    layer_serializer_if #(.NN(NN), .dataWidth(DW)) bus ();

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        step();
        bus.in_valid = '0;
    endtask

    task automatic expectFrame(input logic [NN*DW-1:0] d);
        for (int i = 0; i < NN; i++) begin
            expQ.push_back('{data: d[i*DW +: DW], last: (i == NN - 1)});
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || bus.out_valid) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("[TB] FAIL %s: drain timeout, got %0d words pending, expected 0", name, expQ.size());
        end
    endtask

    // Monitor: compares accepted words against the scoreboard and checks held words under stall.
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevData  = '0;
    logic          prevLast  = 1'b0;
    always @(negedge clk) begin
        expWord_t e;
        if (!rstn) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallValid", {31'd0, bus.out_valid}, 32'd1);
                checkOutput("stallData", {16'd0, bus.out_data}, {16'd0, prevData});
                checkOutput("stallLast", {31'd0, bus.out_last}, {31'd0, prevLast});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWord: got 0x%0h, expected no word", bus.out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wordData", {16'd0, bus.out_data}, {16'd0, e.data});
                    checkOutput("wordLast", {31'd0, bus.out_last}, {31'd0, e.last});
                end
                hsCount++;
                if (bus.out_last) lastCount++;
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
        end
    end

    initial begin
        int early;
        int gaps;
        int hs0;
        int last0;

        rstn          = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        checkOutput("rstValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rstLast", {31'd0, bus.out_last}, 32'd0);
        checkOutput("rstData", {16'd0, bus.out_data}, 32'd0);
        checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rstOverflow", {31'd0, bus.overflow}, 32'd0);
        rstn = 1'b1;
        step();

        $display("[TB] single frame");
        expectFrame({16'h0044, 16'h0033, 16'h0022, 16'h0011});
        applyStimulus(4'b1111, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
        checkOutput("latencyValid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("latencyData", {16'd0, bus.out_data}, 32'h0011);
        checkOutput("frameBusy", {31'd0, bus.busy}, 32'd1);
        waitDrain("singleDrain");
        checkOutput("singleIdleBusy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] skewed lanes");
        early = 0;
        expectFrame({16'h3D3D, 16'h2C2C, 16'h1B1B, 16'h0A0A});
        applyStimulus(4'b0100, {16'hEEEE, 16'h2C2C, 16'hEEEE, 16'hEEEE});
        if (bus.out_valid) early++;
        repeat (2) begin step(); if (bus.out_valid) early++; end
        applyStimulus(4'b1001, {16'h3D3D, 16'hDEAD, 16'hEEEE, 16'h0A0A});
        if (bus.out_valid) early++;
        checkOutput("skewBusy", {31'd0, bus.busy}, 32'd1);
        repeat (3) begin step(); if (bus.out_valid) early++; end
        applyStimulus(4'b0010, {16'hEEEE, 16'hEEEE, 16'h1B1B, 16'hEEEE});
        checkOutput("skewEarly", early, 32'd0);
        checkOutput("skewValid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("skewOverflow", {31'd0, bus.overflow}, 32'd0);
        waitDrain("skewDrain");

        $display("[TB] backpressure");
        hs0   = hsCount;
        last0 = lastCount;
        expectFrame({16'hD004, 16'hC003, 16'hB002, 16'hA001});
        applyStimulus(4'b1111, {16'hD004, 16'hC003, 16'hB002, 16'hA001});
        for (int k = 0; k < 20; k++) begin
            bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            step();
        end
        bus.out_ready = 1'b1;
        checkOutput("bpHandshakes", hsCount - hs0, 32'd4);
        checkOutput("bpLasts", lastCount - last0, 32'd1);
        checkOutput("bpQueue", expQ.size(), 32'd0);

        $display("[TB] back-to-back frames");
        gaps  = 0;
        last0 = lastCount;
        expectFrame({16'h1004, 16'h1003, 16'h1002, 16'h1001});
        expectFrame({16'h2004, 16'h2003, 16'h2002, 16'h2001});
        applyStimulus(4'b1111, {16'h1004, 16'h1003, 16'h1002, 16'h1001});
        if (!bus.out_valid) gaps++;
        applyStimulus(4'b1111, {16'h2004, 16'h2003, 16'h2002, 16'h2001});
        if (!bus.out_valid) gaps++;
        repeat (6) begin step(); if (!bus.out_valid) gaps++; end
        step();
        checkOutput("b2bGaps", gaps, 32'd0);
        checkOutput("b2bEndValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("b2bLasts", lastCount - last0, 32'd2);

        $display("[TB] overflow");
        bus.out_ready = 1'b0;
        expectFrame({16'h5004, 16'h5003, 16'h5002, 16'h5001});
        expectFrame({16'h6004, 16'h6003, 16'h6002, 16'h6001});
        applyStimulus(4'b1111, {16'h5004, 16'h5003, 16'h5002, 16'h5001});
        applyStimulus(4'b1111, {16'h6004, 16'h6003, 16'h6002, 16'h6001});
        checkOutput("ovfBefore", {31'd0, bus.overflow}, 32'd0);
        applyStimulus(4'b0010, {16'h0000, 16'h0000, 16'hBEEF, 16'h0000});
        checkOutput("ovfSet", {31'd0, bus.overflow}, 32'd1);
        repeat (3) step();
        checkOutput("ovfSticky", {31'd0, bus.overflow}, 32'd1);
        checkOutput("ovfHeldData", {16'd0, bus.out_data}, 32'h5001);
        bus.out_ready = 1'b1;
        waitDrain("ovfDrain");
        checkOutput("ovfAfterDrain", {31'd0, bus.overflow}, 32'd1);

        $display("[TB] reset mid-drain");
        expQ.push_back('{data: 16'h7001, last: 1'b0});
        expQ.push_back('{data: 16'h7002, last: 1'b0});
        applyStimulus(4'b1111, {16'h7004, 16'h7003, 16'h7002, 16'h7001});
        step();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checkOutput("midRstValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midRstOverflow", {31'd0, bus.overflow}, 32'd0);
        checkOutput("midRstBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midRstQueue", expQ.size(), 32'd0);
        step();
        checkOutput("midRstNoResume", {31'd0, bus.out_valid}, 32'd0);
        expectFrame({16'h8004, 16'h8003, 16'h8002, 16'h8001});
        applyStimulus(4'b1111, {16'h8004, 16'h8003, 16'h8002, 16'h8001});
        checkOutput("postRstFirst", {16'd0, bus.out_data}, 32'h8001);
        waitDrain("postRstDrain");
        checkOutput("finalBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("finalQueue", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Reader end of a layer output bus. Collects the NN parallel neuron results (per-neuron valid strobes, flat packed data bus) of one fully-parallel layer into a frame.
- Replays the frame one word per cycle as a ready/valid stream. Feeds the next layer's serial x_in/x_valid input, or the output argmax/AXI stage.
- Double-buffered (fill + drain), so a new layer result can be collected while the previous one is draining.

Parameters:
NN, 30, number of neurons (lanes) in the producing layer; must be >= 2
dataWidth, 16, width of one neuron output word
IDXW, $clog2(NN), width of the drain index counter (derived, localparam)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
in_valid  input  NN  per-neuron output valid strobes; bit i qualifies lane i
in_data  input  NN*dataWidth  packed neuron outputs; lane i = bits [i*dataWidth +: dataWidth]
out_ready  input  1  downstream accepts word when high
out_valid  output  1  out_data holds a valid word
out_data  output  dataWidth  current word; lane 0 first, lane NN-1 last
out_last  output  1  high with the word of lane NN-1
busy  output  1  fill mask non-zero OR drain buffer occupied
overflow  output  1  sticky error flag

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low, on clk/rstn.
- Reset values: out_valid=0, out_last=0, out_data=0, busy=0, overflow=0, fill mask=0, drain occupied=0, drain index=0. Reset mid-drain discards both buffers; no partial frame is emitted afterwards.
- Fill buffer:
  - NN data registers plus an NN-bit lane mask.
  - At a clock edge with in_valid[i]=1 and mask[i]=0: capture lane i and set mask[i].
  - With in_valid[i]=1 and mask[i]=1 (lane already captured, frame not yet transferred): keep the old data, set overflow. overflow clears only on reset.
  - Lanes may complete in any order and across any number of cycles (skew tolerated).
- Fill complete: (mask | accepted in_valid) == all ones.
- Transfer: at the edge where the fill is complete and the drain is empty (or freeing this edge), copy the fill into the drain.
  - Merged data is copied, including lanes arriving this same cycle.
  - The mask clears to 0 at that edge.
  - in_valid lanes arriving at the transfer edge whose mask bit was already set before the edge start a fresh fill (mask = those bits), no overflow.
- Drain:
  - Occupied: out_valid=1 and out_data=drain[index].
  - Handshake when out_valid && out_ready; index then increments.
  - out_last = occupied && index==NN-1.
  - Handshake at index NN-1: index returns to 0. If a complete fill is waiting or completing this edge, the drain reloads at the same edge with no bubble; otherwise occupied clears.
  - out_valid=1 with out_ready=0: out_data and out_last must hold stable.
- Latency: the last lane valid at cycle t with an empty drain gives out_valid=1 in cycle t+1 carrying lane 0. Minimum frame period is NN cycles with out_ready tied high.
- Fill complete while the drain is busy: the fill waits (mask stays all ones). Any further in_valid bit on it sets overflow, and that data is dropped.
- busy: registered view of (mask!=0 || occupied).

Test Plan:
- Single frame, NN=4, dataWidth=16: in_valid=4'b1111 with lanes 0x0011,0x0022,0x0033,0x0044, out_ready=1 -> out_valid one cycle later; words 0x0011,0x0022,0x0033,0x0044 on consecutive cycles; out_last only with 0x0044; busy low afterwards.
- Skewed lanes: lane2 at cycle 0, lanes 0,3 at cycle 3, lane1 at cycle 7 -> no output before cycle 8; then lane order 0,1,2,3; overflow=0.
- Backpressure: out_ready toggles 1,0,0,1,... -> each word is held stable while stalled; no word is lost or duplicated; exactly 4 handshakes, the last with out_last.
- Back-to-back frames: second frame completes during the first drain; out_ready=1 -> 8 consecutive valid words with no gap; out_last on words 4 and 8.
- Overflow: frame A complete, out_ready=0, then in_valid[1] pulses with 0xBEEF -> overflow=1 and stays 1; after release, the stream still shows frame A's lane 1 value.
- Reset mid-drain: rstn=0 for one cycle after word 2 -> next cycle out_valid=0, overflow=0, busy=0; a new frame then drains starting at lane 0.
